// File: rtl/alu_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// alu_rr_arbiter_if
//   Bundles every bus of the ALU arbiter: the NREQ request channels, the
//   ALU drive/return wires and the single tagged response channel.
//   Clock and reset are not part of the bundle.
//
//   slave  : the arbiter's view (consumes requests and ALU results, drives
//            grants, ALU inputs and the response)
//   master : the environment's view (requesters, response consumer, ALU)
// ---------------------------------------------------------------------------
interface alu_rr_arbiter_if #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
);
   // request side, requester i at [32*i+:32] / [3*i+:3]
   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ*32-1:0] req_a;
   logic [NREQ*32-1:0] req_b;
   logic [NREQ*3-1:0]  req_op;

   // ALU side
   logic [31:0]        alu_a;
   logic [31:0]        alu_b;
   logic [2:0]         alu_sel;
   logic [31:0]        alu_out;
   logic               alu_carry;
   logic               alu_ovf;

   // response side
   logic               rsp_valid;
   logic               rsp_ready;
   logic [IDW-1:0]     rsp_id;
   logic [31:0]        rsp_result;
   logic [3:0]         rsp_flags;   // {zero, neg, carry, ovf}
   logic               rsp_err;

   modport slave (
      input  req_valid, req_a, req_b, req_op,
      input  alu_out, alu_carry, alu_ovf,
      input  rsp_ready,
      output req_ready,
      output alu_a, alu_b, alu_sel,
      output rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err
   );

   modport master (
      output req_valid, req_a, req_b, req_op,
      output alu_out, alu_carry, alu_ovf,
      output rsp_ready,
      input  req_ready,
      input  alu_a, alu_b, alu_sel,
      input  rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err
   );
endinterface

// File: rtl/alu_rr_arbiter.sv
// ---------------------------------------------------------------------------
// alu_rr_arbiter
//   Shares one combinational 32-bit ALU (ADD/SUB/OR/AND/SLT) between NREQ
//   requesters. A round-robin pick accepts one request, its operands are
//   registered onto the ALU inputs for one cycle, the result and flags are
//   captured, and they are returned on a single tagged response channel.
//
//   Ports
//     clk  : clock, all state changes on the rising edge
//     rst  : synchronous active-high reset
//     bus  : alu_rr_arbiter_if.slave
//              req_valid/req_ready/req_a/req_b/req_op  request channels
//              alu_a/alu_b/alu_sel -> ALU, alu_out/alu_carry/alu_ovf <- ALU
//              rsp_valid/rsp_ready/rsp_id/rsp_result/rsp_flags/rsp_err
//
//   Op codes: 0 ADD, 1 SUB, 2 OR, 3 AND, 4 SLT (signed); 5..7 illegal.
//   Timing: accept edge -> rsp_valid two cycles later; one op per three
//   cycles at best. IDW must equal clog2(NREQ).
// ---------------------------------------------------------------------------
module alu_rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic            clk,
   input  logic            rst,
   alu_rr_arbiter_if.slave bus
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

   state_t          state_q, state_d;
   logic [IDW-1:0]  ptr_q, ptr_d;
   logic [31:0]     op_a_q, op_a_d;
   logic [31:0]     op_b_q, op_b_d;
   logic [2:0]      op_sel_q, op_sel_d;
   logic [IDW-1:0]  op_id_q, op_id_d;
   logic [31:0]     rsp_result_q, rsp_result_d;
   logic [3:0]      rsp_flags_q, rsp_flags_d;
   logic            rsp_err_q, rsp_err_d;

   logic [31:0]     req_a_arr  [NREQ];
   logic [31:0]     req_b_arr  [NREQ];
   logic [2:0]      req_op_arr [NREQ];
   logic [IDW-1:0]  cand_idx   [NREQ];
   logic [NREQ-1:0] cand_valid;

   logic            grant_found;
   logic [IDW-1:0]  grant_id;
   logic [NREQ-1:0] grant_onehot;
   logic [NREQ-1:0] req_ready_d;
   logic [IDW:0]    id_inc;
   logic            op_legal;
   logic            op_arith;

   // Per-requester unpacking, plus the round-robin candidate list:
   // candidate k is requester (ptr + k) mod NREQ, so candidate 0 is the
   // highest-priority slot. The explicit wrap keeps indices >= NREQ out of
   // the scan when NREQ is not a power of two.
   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_req
         logic [IDW:0] slot_sum;

         assign req_a_arr[gi]  = bus.req_a[32*gi +: 32];
         assign req_b_arr[gi]  = bus.req_b[32*gi +: 32];
         assign req_op_arr[gi] = bus.req_op[3*gi +: 3];

         assign slot_sum       = {1'b0, ptr_q} + (IDW+1)'(gi);
         assign cand_idx[gi]   = (slot_sum >= NREQ_W) ? IDW'(slot_sum - NREQ_W)
                                                      : slot_sum[IDW-1:0];
         assign cand_valid[gi] = |(bus.req_valid & (NREQ'(1) << cand_idx[gi]));
      end
   endgenerate

   // First valid candidate wins.
   always_comb begin
      grant_found = 1'b0;
      grant_id    = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!grant_found && cand_valid[k]) begin
            grant_found = 1'b1;
            grant_id    = cand_idx[k];
         end
      end
   end

   assign grant_onehot = NREQ'(1) << grant_id;
   assign op_legal     = (op_sel_q <= 3'd4);
   // Carry and overflow mean something only for ADD and SUB.
   assign op_arith     = (op_sel_q <= 3'd1);
   assign id_inc       = {1'b0, op_id_q} + (IDW+1)'(1);

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      op_a_d       = op_a_q;
      op_b_d       = op_b_q;
      op_sel_d     = op_sel_q;
      op_id_d      = op_id_q;
      rsp_result_d = rsp_result_q;
      rsp_flags_d  = rsp_flags_q;
      rsp_err_d    = rsp_err_q;
      req_ready_d  = '0;

      case (state_q)
         S_IDLE: begin
            if (grant_found) begin
               req_ready_d = grant_onehot;
               op_a_d      = req_a_arr[grant_id];
               op_b_d      = req_b_arr[grant_id];
               op_sel_d    = req_op_arr[grant_id];
               op_id_d     = grant_id;
               state_d     = S_EXEC;
            end
         end

         S_EXEC: begin
            // The ALU is still driven with an illegal code for this cycle;
            // whatever it returns is discarded.
            if (op_legal) begin
               rsp_result_d = bus.alu_out;
               rsp_flags_d  = {bus.alu_out == 32'd0,
                               bus.alu_out[31],
                               bus.alu_carry & op_arith,
                               bus.alu_ovf & op_arith};
               rsp_err_d    = 1'b0;
            end else begin
               rsp_result_d = '0;
               rsp_flags_d  = '0;
               rsp_err_d    = 1'b1;
            end
            state_d = S_RESP;
         end

         S_RESP: begin
            // The requester just served drops to lowest priority.
            if (bus.rsp_ready) begin
               ptr_d   = (id_inc >= NREQ_W) ? '0 : id_inc[IDW-1:0];
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         ptr_q        <= '0;
         op_a_q       <= '0;
         op_b_q       <= '0;
         op_sel_q     <= '0;
         op_id_q      <= '0;
         rsp_result_q <= '0;
         rsp_flags_q  <= '0;
         rsp_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         op_a_q       <= op_a_d;
         op_b_q       <= op_b_d;
         op_sel_q     <= op_sel_d;
         op_id_q      <= op_id_d;
         rsp_result_q <= rsp_result_d;
         rsp_flags_q  <= rsp_flags_d;
         rsp_err_q    <= rsp_err_d;
      end
   end

   // A grant is never shown while reset is held, even though the state
   // register only clears at the next edge.
   assign bus.req_ready  = rst ? '0 : req_ready_d;
   assign bus.alu_a      = op_a_q;
   assign bus.alu_b      = op_b_q;
   assign bus.alu_sel    = op_sel_q;
   assign bus.rsp_valid  = (state_q == S_RESP);
   assign bus.rsp_id     = op_id_q;
   assign bus.rsp_result = rsp_result_q;
   assign bus.rsp_flags  = rsp_flags_q;
   assign bus.rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_rr_arbiter
//   Directed scenarios plus a randomized run for alu_rr_arbiter. The bench
//   plays the requesters, the response consumer and the ALU. Expected
//   results come from an arithmetic reference (64-bit integer maths) and a
//   transaction-level arbitration model (pointer + busy age).
// ---------------------------------------------------------------------------
module tb_alu_rr_arbiter;
   localparam int NREQ = 4;
   localparam int IDW  = 2;

   typedef struct packed {
      logic [31:0] result;
      logic [3:0]  flags;
      logic        err;
   } exp_t;

   // {rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err}
   typedef logic [1+IDW+32+4+1-1:0] rsp_vec_t;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   logic [NREQ-1:0] drv_valid;
   logic [31:0]     drv_a  [NREQ];
   logic [31:0]     drv_b  [NREQ];
   logic [2:0]      drv_op [NREQ];
   rsp_vec_t        rsp_obs;

   alu_rr_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

   alu_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign bus.req_valid = drv_valid;
   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_drv
         assign bus.req_a[32*gi +: 32] = drv_a[gi];
         assign bus.req_b[32*gi +: 32] = drv_b[gi];
         assign bus.req_op[3*gi +: 3]  = drv_op[gi];
      end
   endgenerate

   assign rsp_obs = {bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_flags, bus.rsp_err};

   // ALU stand-in. SUB reports borrow as carry. Non-arithmetic and illegal
   // codes return carry/ovf = 1 and illegal codes return junk, so the
   // arbiter's masking is visible.
   always_comb begin : alu_model
      logic [32:0] w;
      w             = '0;
      bus.alu_out   = 32'h0;
      bus.alu_carry = 1'b1;
      bus.alu_ovf   = 1'b1;
      case (bus.alu_sel)
         3'd0: begin
            w             = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
            bus.alu_out   = w[31:0];
            bus.alu_carry = w[32];
            bus.alu_ovf   = (bus.alu_a[31] == bus.alu_b[31]) && (w[31] != bus.alu_a[31]);
         end
         3'd1: begin
            w             = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
            bus.alu_out   = w[31:0];
            bus.alu_carry = w[32];
            bus.alu_ovf   = (bus.alu_a[31] != bus.alu_b[31]) && (w[31] != bus.alu_a[31]);
         end
         3'd2: bus.alu_out = bus.alu_a | bus.alu_b;
         3'd3: bus.alu_out = bus.alu_a & bus.alu_b;
         3'd4: bus.alu_out = ($signed(bus.alu_a) < $signed(bus.alu_b)) ? 32'd1 : 32'd0;
         default: bus.alu_out = bus.alu_a ^ bus.alu_b ^ 32'hDEAD_BEEF;
      endcase
   end

   // Reference: exact integer arithmetic, flags derived from the definition
   // (carry = unsigned result out of range, ovf = signed result out of range).
   function automatic exp_t ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
      exp_t   e;
      longint ua, ub, sa, sb, r, s;
      logic   c, v;
      e  = '0;
      c  = 1'b0;
      v  = 1'b0;
      ua = {32'd0, a};
      ub = {32'd0, b};
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         3'd0: begin
            r = ua + ub;  e.result = r[31:0];
            c = (r >= 64'sh1_0000_0000);
            s = sa + sb;  v = (s != longint'($signed(e.result)));
         end
         3'd1: begin
            r = ua - ub;  e.result = r[31:0];
            c = (r < 0);
            s = sa - sb;  v = (s != longint'($signed(e.result)));
         end
         3'd2: e.result = a | b;
         3'd3: e.result = a & b;
         3'd4: e.result = (sa < sb) ? 32'd1 : 32'd0;
         default: e.err = 1'b1;
      endcase
      if (!e.err) e.flags = {e.result == 32'd0, e.result[31], c, v};
      return e;
   endfunction

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 4))
         0: return 32'($urandom_range(0, 9));
         1: return 32'h7FFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'hFFFF_FFFF;
         default: return 32'($urandom);
      endcase
   endfunction

   // ---- stimulus helpers (no checking inside) ----
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_reqs();
      drv_valid = '0;
      for (int i = 0; i < NREQ; i++) begin
         drv_a[IDW'(i)]  = '0;
         drv_b[IDW'(i)]  = '0;
         drv_op[IDW'(i)] = '0;
      end
   endtask

   task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
      drv_a[IDW'(i)]     = a;
      drv_b[IDW'(i)]     = b;
      drv_op[IDW'(i)]    = op;
      drv_valid[IDW'(i)] = 1'b1;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      clear_reqs();
      step();
      step();
      rst = 1'b0;
   endtask

   // Full single transaction from an idle arbiter with rsp_ready=1:
   // returns the grant seen in the request cycle and the response seen two
   // cycles later.
   task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                        output logic [NREQ-1:0] gnt, output rsp_vec_t obs);
      set_req(i, a, b, op);
      #1;
      gnt = bus.req_ready;
      step();
      drv_valid[IDW'(i)] = 1'b0;
      step();
      obs = rsp_obs;
      $display("txn req=%0d op=%0d a=%h b=%h -> valid=%b id=%0d result=%h flags=%b err=%b",
               i, op, a, b, obs[39], obs[38:37], obs[36:5], obs[4:1], obs[0]);
      step();
   endtask

   // ---- scenarios ----
   task automatic test_reset();
      rst = 1'b1;
      clear_reqs();
      drv_valid = '1;
      bus.rsp_ready = 1'b1;
      step();
      step();
      n_checks++;
      if (bus.req_ready !== '0) begin
         n_errors++; $display("FAIL reset_req_ready: got %b want 0", bus.req_ready);
      end
      n_checks++;
      if ({bus.alu_a, bus.alu_b, bus.alu_sel} !== '0) begin
         n_errors++; $display("FAIL reset_alu: got a=%h b=%h sel=%0d want 0", bus.alu_a, bus.alu_b, bus.alu_sel);
      end
      n_checks++;
      if (rsp_obs !== '0) begin
         n_errors++; $display("FAIL reset_rsp: got %h want 0", rsp_obs);
      end
      drv_valid = '0;
      rst = 1'b0;
      step();
   endtask

   task automatic test_single_add();
      bus.rsp_ready = 1'b1;
      set_req(0, 32'd5, 32'd7, 3'd0);
      #1;
      n_checks++;
      if (bus.req_ready !== 4'b0001) begin
         n_errors++; $display("FAIL add_grant: got %b want 0001", bus.req_ready);
      end
      step();
      drv_valid[0] = 1'b0;
      n_checks++;
      if ({bus.rsp_valid, bus.alu_a, bus.alu_b, bus.alu_sel} !== {1'b0, 32'd5, 32'd7, 3'd0}) begin
         n_errors++; $display("FAIL add_exec: got v=%b a=%h b=%h sel=%0d want v=0 a=5 b=7 sel=0",
                              bus.rsp_valid, bus.alu_a, bus.alu_b, bus.alu_sel);
      end
      step();
      n_checks++;
      if (rsp_obs !== {1'b1, 2'd0, 32'd12, 4'b0000, 1'b0}) begin
         n_errors++; $display("FAIL add_rsp: got %h want %h", rsp_obs, {1'b1, 2'd0, 32'd12, 4'b0000, 1'b0});
      end
      $display("txn req=0 op=0 a=5 b=7 -> id=%0d result=%h", bus.rsp_id, bus.rsp_result);
      step();
      n_checks++;
      if (bus.rsp_valid !== 1'b0) begin
         n_errors++; $display("FAIL add_rsp_drop: got %b want 0", bus.rsp_valid);
      end
   endtask

   task automatic test_sub_slt();
      logic [NREQ-1:0] gnt;
      rsp_vec_t        obs;
      bus.rsp_ready = 1'b1;
      issue(1, 32'd3, 32'd5, 3'd1, gnt, obs);
      n_checks++;
      if (gnt !== 4'b0010) begin
         n_errors++; $display("FAIL sub_grant: got %b want 0010", gnt);
      end
      n_checks++;
      if (obs !== {1'b1, 2'd1, 32'hFFFF_FFFE, 4'b0110, 1'b0}) begin
         n_errors++; $display("FAIL sub_rsp: got %h want %h", obs, {1'b1, 2'd1, 32'hFFFF_FFFE, 4'b0110, 1'b0});
      end
      issue(1, 32'hFFFF_FFFF, 32'd1, 3'd4, gnt, obs);
      n_checks++;
      if (obs !== {1'b1, 2'd1, 32'd1, 4'b0000, 1'b0}) begin
         n_errors++; $display("FAIL slt_rsp: got %h want %h", obs, {1'b1, 2'd1, 32'd1, 4'b0000, 1'b0});
      end
   endtask

   task automatic test_flags();
      logic [NREQ-1:0] gnt;
      rsp_vec_t        obs;
      logic [31:0]     fa [5] = '{32'd1, 32'h7FFF_FFFF, 32'hF0F0_F0F0, 32'h8000_0000, 32'd5};
      logic [31:0]     fb [5] = '{32'hFFFF_FFFF, 32'd1, 32'h0FF0_0FF0, 32'd1, 32'd5};
      logic [2:0]      fo [5] = '{3'd0, 3'd0, 3'd3, 3'd2, 3'd1};
      int              fr [5] = '{0, 0, 3, 3, 2};
      rsp_vec_t        fw [5] = '{{1'b1, 2'd0, 32'h0,         4'b1010, 1'b0},
                                  {1'b1, 2'd0, 32'h8000_0000, 4'b0101, 1'b0},
                                  {1'b1, 2'd3, 32'h00F0_00F0, 4'b0000, 1'b0},
                                  {1'b1, 2'd3, 32'h8000_0001, 4'b0100, 1'b0},
                                  {1'b1, 2'd2, 32'h0,         4'b1000, 1'b0}};
      bus.rsp_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         issue(fr[k], fa[k], fb[k], fo[k], gnt, obs);
         n_checks++;
         if (obs !== fw[k]) begin
            n_errors++; $display("FAIL flags_%0d: got %h want %h", k, obs, fw[k]);
         end
      end
   endtask

   task automatic test_round_robin();
      int       order [5] = '{0, 1, 2, 3, 0};
      rsp_vec_t want;
      apply_reset();
      bus.rsp_ready = 1'b1;
      for (int i = 0; i < NREQ; i++) set_req(i, 32'(i), 32'd0, 3'd0);
      for (int k = 0; k < 5; k++) begin
         #1;
         n_checks++;
         if (bus.req_ready !== (NREQ'(1) << order[k])) begin
            n_errors++; $display("FAIL rr_grant_%0d: got %b want %b", k, bus.req_ready, NREQ'(1) << order[k]);
         end
         step();
         step();
         want = {1'b1, IDW'(order[k]), 32'(order[k]), 4'(order[k] == 0 ? 8 : 0), 1'b0};
         n_checks++;
         if (rsp_obs !== want) begin
            n_errors++; $display("FAIL rr_rsp_%0d: got %h want %h", k, rsp_obs, want);
         end
         $display("txn rr k=%0d id=%0d result=%h", k, bus.rsp_id, bus.rsp_result);
         step();
      end
      clear_reqs();
   endtask

   task automatic test_illegal();
      logic [NREQ-1:0] gnt;
      rsp_vec_t        obs;
      bus.rsp_ready = 1'b1;
      issue(2, 32'h1234, 32'h5678, 3'd6, gnt, obs);
      n_checks++;
      if (gnt !== 4'b0100) begin
         n_errors++; $display("FAIL illegal_grant: got %b want 0100", gnt);
      end
      n_checks++;
      if (obs !== {1'b1, 2'd2, 32'd0, 4'b0000, 1'b1}) begin
         n_errors++; $display("FAIL illegal_rsp: got %h want %h", obs, {1'b1, 2'd2, 32'd0, 4'b0000, 1'b1});
      end
      issue(2, 32'd10, 32'd20, 3'd0, gnt, obs);
      n_checks++;
      if (obs !== {1'b1, 2'd2, 32'd30, 4'b0000, 1'b0}) begin
         n_errors++; $display("FAIL after_illegal_rsp: got %h want %h", obs, {1'b1, 2'd2, 32'd30, 4'b0000, 1'b0});
      end
   endtask

   task automatic test_backpressure();
      rsp_vec_t want;
      want = {1'b1, 2'd0, 32'd123, 4'b0000, 1'b0};
      bus.rsp_ready = 1'b0;
      set_req(0, 32'd100, 32'd23, 3'd0);
      #1;
      n_checks++;
      if (bus.req_ready !== 4'b0001) begin
         n_errors++; $display("FAIL bp_grant0: got %b want 0001", bus.req_ready);
      end
      step();
      drv_valid[0] = 1'b0;
      step();
      set_req(3, 32'd8, 32'd2, 3'd1);
      for (int c = 0; c < 10; c++) begin
         #1;
         n_checks++;
         if (rsp_obs !== want || bus.req_ready !== '0) begin
            n_errors++; $display("FAIL bp_hold_%0d: got rsp=%h ready=%b want rsp=%h ready=0", c, rsp_obs, bus.req_ready, want);
         end
         step();
      end
      bus.rsp_ready = 1'b1;
      #1;
      n_checks++;
      if (bus.req_ready !== '0 || bus.rsp_valid !== 1'b1) begin
         n_errors++; $display("FAIL bp_handshake: got ready=%b valid=%b want ready=0 valid=1", bus.req_ready, bus.rsp_valid);
      end
      $display("txn bp req=0 id=%0d result=%h", bus.rsp_id, bus.rsp_result);
      step();
      n_checks++;
      if (bus.req_ready !== 4'b1000 || bus.rsp_valid !== 1'b0) begin
         n_errors++; $display("FAIL bp_grant3: got ready=%b valid=%b want ready=1000 valid=0", bus.req_ready, bus.rsp_valid);
      end
      step();
      drv_valid[3] = 1'b0;
      step();
      n_checks++;
      if (rsp_obs !== {1'b1, 2'd3, 32'd6, 4'b0000, 1'b0}) begin
         n_errors++; $display("FAIL bp_rsp3: got %h want %h", rsp_obs, {1'b1, 2'd3, 32'd6, 4'b0000, 1'b0});
      end
      $display("txn bp req=3 id=%0d result=%h", bus.rsp_id, bus.rsp_result);
      step();
   endtask

   task automatic test_reset_exec();
      bus.rsp_ready = 1'b1;
      set_req(1, 32'd9, 32'd4, 3'd1);
      #1;
      n_checks++;
      if (bus.req_ready !== 4'b0010) begin
         n_errors++; $display("FAIL rx_grant: got %b want 0010", bus.req_ready);
      end
      step();
      drv_valid = '0;
      n_checks++;
      if ({bus.alu_a, bus.alu_sel} !== {32'd9, 3'd1}) begin
         n_errors++; $display("FAIL rx_exec: got a=%h sel=%0d want a=9 sel=1", bus.alu_a, bus.alu_sel);
      end
      rst = 1'b1;
      drv_valid = '1;
      #1;
      n_checks++;
      if (bus.req_ready !== '0) begin
         n_errors++; $display("FAIL rx_ready_in_rst: got %b want 0", bus.req_ready);
      end
      step();
      n_checks++;
      if ({bus.rsp_valid, bus.alu_a, bus.alu_b, bus.alu_sel} !== '0) begin
         n_errors++; $display("FAIL rx_after_rst: got v=%b a=%h b=%h sel=%0d want 0", bus.rsp_valid, bus.alu_a, bus.alu_b, bus.alu_sel);
      end
      rst = 1'b0;
      drv_valid = '0;
      for (int c = 0; c < 4; c++) begin
         step();
         n_checks++;
         if (bus.rsp_valid !== 1'b0) begin
            n_errors++; $display("FAIL rx_no_rsp_%0d: got %b want 0", c, bus.rsp_valid);
         end
      end
      for (int i = 0; i < NREQ; i++) set_req(i, 32'(40 + i), 32'd0, 3'd0);
      #1;
      n_checks++;
      if (bus.req_ready !== 4'b0001) begin
         n_errors++; $display("FAIL rx_ptr_reset: got %b want 0001", bus.req_ready);
      end
      step();
      drv_valid = '0;
      step();
      n_checks++;
      if (rsp_obs !== {1'b1, 2'd0, 32'd40, 4'b0000, 1'b0}) begin
         n_errors++; $display("FAIL rx_rsp: got %h want %h", rsp_obs, {1'b1, 2'd0, 32'd40, 4'b0000, 1'b0});
      end
      $display("txn rx id=%0d result=%h", bus.rsp_id, bus.rsp_result);
      step();
   endtask

   // Random requesters (appear, hold, occasionally withdraw) and a random
   // consumer. Model: a pointer and the age of the single op in flight.
   task automatic test_random(input int ncycles);
      logic [NREQ-1:0] pend;
      logic [NREQ-1:0] exp_ready;
      int              model_ptr, age, g, cur_id, idx;
      exp_t            cur;
      rsp_vec_t        want;
      apply_reset();
      pend      = '0;
      model_ptr = 0;
      age       = -1;
      cur_id    = 0;
      cur       = '0;
      for (int c = 0; c < ncycles; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!pend[IDW'(i)]) begin
               if ($urandom_range(0, 2) == 0) begin
                  pend[IDW'(i)] = 1'b1;
                  set_req(i, rand_operand(), rand_operand(), 3'($urandom_range(0, 7)));
               end
            end else if ($urandom_range(0, 19) == 0) begin
               pend[IDW'(i)] = 1'b0;
            end
         end
         drv_valid     = pend;
         bus.rsp_ready = ($urandom_range(0, 3) != 0);
         #1;
         g = -1;
         if (age < 0) begin
            for (int k = 0; k < NREQ; k++) begin
               idx = (model_ptr + k) % NREQ;
               if (g < 0 && pend[IDW'(idx)]) g = idx;
            end
         end
         exp_ready = (g >= 0) ? (NREQ'(1) << g) : '0;
         n_checks++;
         if (bus.req_ready !== exp_ready) begin
            n_errors++; $display("FAIL rnd_grant c=%0d: got %b want %b", c, bus.req_ready, exp_ready);
         end
         if (age >= 1) begin
            want = {1'b1, IDW'(cur_id), cur.result, cur.flags, cur.err};
            n_checks++;
            if (rsp_obs !== want) begin
               n_errors++; $display("FAIL rnd_rsp c=%0d: got %h want %h", c, rsp_obs, want);
            end
         end else begin
            n_checks++;
            if (bus.rsp_valid !== 1'b0) begin
               n_errors++; $display("FAIL rnd_idle_valid c=%0d: got %b want 0", c, bus.rsp_valid);
            end
         end
         if (g >= 0) begin
            cur    = ref_alu(drv_a[IDW'(g)], drv_b[IDW'(g)], drv_op[IDW'(g)]);
            cur_id = g;
            age    = 0;
            pend[IDW'(g)] = 1'b0;
         end else if (age >= 1 && bus.rsp_ready) begin
            $display("txn rnd c=%0d id=%0d result=%h flags=%b err=%b", c, cur_id, cur.result, cur.flags, cur.err);
            model_ptr = (cur_id + 1) % NREQ;
            age       = -1;
         end else if (age == 0) begin
            age = 1;
         end
         step();
      end
      clear_reqs();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks      = 0;
      n_errors      = 0;
      rst           = 1'b1;
      bus.rsp_ready = 1'b0;
      clear_reqs();
      test_reset();
      test_single_add();
      test_sub_slt();
      test_flags();
      test_round_robin();
      test_illegal();
      test_backpressure();
      test_reset_exec();
      test_random(600);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
